// File: rtl/alu_share_arbiter_if.sv
// Requester and result handshake bundle for alu_share_arbiter.
// Optional flag signals out_zero/out_carry exist only when ALU_FLAGS_EN is defined.
interface alu_share_arbiter_if #(
    parameter int W = 32
);
    logic         req0;
    logic [2:0]   op0;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic         cin0;
    logic         ack0;

    logic         req1;
    logic [2:0]   op1;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         cin1;
    logic         ack1;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_id;
    logic         busy;
`ifdef ALU_FLAGS_EN
    logic         out_zero;
    logic         out_carry;
`endif

    // master = requesters plus writeback side, slave = the arbiter itself
    modport master (
        output req0, op0, a0, b0, cin0,
        output req1, op1, a1, b1, cin1,
        output out_ready,
        input  ack0, ack1, out_valid, out_result, out_id, busy
`ifdef ALU_FLAGS_EN
        , input out_zero, out_carry
`endif
    );

    modport slave (
        input  req0, op0, a0, b0, cin0,
        input  req1, op1, a1, b1, cin1,
        input  out_ready,
        output ack0, ack1, out_valid, out_result, out_id, busy
`ifdef ALU_FLAGS_EN
        , output out_zero, out_carry
`endif
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one W-bit ALU between two requesters; IDLE -> EXEC -> DONE -> IDLE.
// Define ALU_FLAGS_EN to add registered out_zero/out_carry result flags.
module alu_share_arbiter #(
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    logic         last_grant;
    logic [2:0]   op_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         cin_q;
    logic         id_q;

    logic         ack0_q;
    logic         ack1_q;
    logic         valid_q;
    logic [W-1:0] result_q;
    logic         id_out_q;
    logic         busy_q;

    logic         any_req;
    logic         grant;
    logic [W-1:0] alu_result;

    assign any_req = bus.req0 | bus.req1;

    // A tie goes to whichever port did not win last time
    always_comb begin
        grant = bus.req1;
        if (bus.req0 && bus.req1) begin
            grant = ~last_grant;
        end
    end

    always_comb begin
        alu_result = '0;
        case (op_q)
            3'b000:  alu_result = a_q;
            3'b001:  alu_result = ~a_q;
            3'b011:  alu_result = a_q & b_q;
            3'b100:  alu_result = a_q | b_q;
            3'b101:  alu_result = a_q - b_q;
            3'b110:  alu_result = a_q + b_q + {{(W-1){1'b0}}, cin_q};
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_q       <= 3'b000;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            id_q       <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            valid_q    <= 1'b0;
            result_q   <= '0;
            id_out_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        id_q       <= grant;
                        last_grant <= grant;
                        op_q       <= grant ? bus.op1  : bus.op0;
                        a_q        <= grant ? bus.a1   : bus.a0;
                        b_q        <= grant ? bus.b1   : bus.b0;
                        cin_q      <= grant ? bus.cin1 : bus.cin0;
                        ack0_q     <= ~grant;
                        ack1_q     <= grant;
                        busy_q     <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    result_q <= alu_result;
                    id_out_q <= id_q;
                    valid_q  <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    // Result stays frozen until writeback takes it; requests wait in IDLE
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack0       = ack0_q;
    assign bus.ack1       = ack1_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_result = result_q;
    assign bus.out_id     = id_out_q;
    assign bus.busy       = busy_q;

`ifdef ALU_FLAGS_EN
    logic [W:0] sum_ext;
    logic       alu_carry;
    logic       zero_q;
    logic       carry_q;

    // Carry is the true W+1-bit carry for add, and "no borrow" (a >= b) for subtract
    always_comb begin
        sum_ext   = {1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, cin_q};
        alu_carry = 1'b0;
        case (op_q)
            3'b101:  alu_carry = (a_q >= b_q);
            3'b110:  alu_carry = sum_ext[W];
            default: alu_carry = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else if (state == EXEC) begin
            zero_q  <= (alu_result == '0);
            carry_q <= alu_carry;
        end
    end

    assign bus.out_zero  = zero_q;
    assign bus.out_carry = carry_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus randomized traffic
// against a plain-arithmetic reference model. Flag checks follow ALU_FLAGS_EN.
module tb_alu_share_arbiter;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;
    int   last_winner = 1;

    always #5 clk = ~clk;

    alu_share_arbiter_if #(.W(W)) bus ();

    alu_share_arbiter #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference ALU: results taken modulo 2^W using 64-bit unsigned arithmetic
    function automatic void ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic cin, output logic [W-1:0] res, output logic carry);
        longint unsigned ua, ub, m, s;
        ua = longint'(a);
        ub = longint'(b);
        m = 64'd1 << W;
        res = '0;
        carry = 1'b0;
        case (op)
            3'd0: res = a;
            3'd1: res = ~a;
            3'd3: res = a & b;
            3'd4: res = a | b;
            3'd5: begin
                s = (ua + m - ub) % m;
                res = s[W-1:0];
                carry = (ua >= ub);
            end
            3'd6: begin
                s = ua + ub + (cin ? 64'd1 : 64'd0);
                res = s[W-1:0];
                carry = (s >= m);
            end
            default: res = '0;
        endcase
    endfunction

    task automatic drive_port(input int p, input logic req, input logic [2:0] op,
                              input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        if (p == 0) begin
            bus.req0 = req; bus.op0 = op; bus.a0 = a; bus.b0 = b; bus.cin0 = cin;
        end else begin
            bus.req1 = req; bus.op1 = op; bus.a1 = a; bus.b1 = b; bus.cin1 = cin;
        end
    endtask

    task automatic wait_ack(output logic [1:0] acks, output bit ok);
        ok = 1'b0;
        acks = 2'b00;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                ok = 1'b1;
                acks = {bus.ack1, bus.ack0};
            end
        end
    endtask

    task automatic observe_single(input int p, input logic [2:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic cin,
                                  output logic [1:0] acks, output bit ack_ok, output logic v1,
                                  output logic [W-1:0] res, output logic id, output logic bsy,
                                  output logic z, output logic c, output logic v2);
        bus.out_ready = 1'b1;
        drive_port(p, 1'b1, op, a, b, cin);
        wait_ack(acks, ack_ok);
        drive_port(p, 1'b0, op, a, b, cin);
        @(negedge clk);
        v1 = bus.out_valid;
        res = bus.out_result;
        id = bus.out_id;
        bsy = bus.busy;
`ifdef ALU_FLAGS_EN
        z = bus.out_zero;
        c = bus.out_carry;
`else
        z = 1'b0;
        c = 1'b0;
`endif
        @(negedge clk);
        v2 = bus.out_valid;
    endtask

    task automatic test_reset();
        logic [1:0] acks;
        bit ok;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_valid: got %b expected 0", bus.out_valid); end
        compared++; if (bus.out_result !== '0) begin mismatched++; $display("[TB] FAIL rst_result: got %h expected 0", bus.out_result); end
        compared++; if (bus.out_id !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_id: got %b expected 0", bus.out_id); end
        compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_busy: got %b expected 0", bus.busy); end
        compared++; if ({bus.ack1, bus.ack0} !== 2'b00) begin mismatched++; $display("[TB] FAIL rst_ack: got %b expected 00", {bus.ack1, bus.ack0}); end
`ifdef ALU_FLAGS_EN
        compared++; if ({bus.out_zero, bus.out_carry} !== 2'b00) begin mismatched++; $display("[TB] FAIL rst_flags: got %b expected 00", {bus.out_zero, bus.out_carry}); end
`endif
        rst_n = 1'b1;
        @(negedge clk);
        drive_port(0, 1'b1, 3'd6, 32'hFFFF_FFFF, 32'h1, 1'b1);
        wait_ack(acks, ok);
        compared++; if (!ok || acks !== 2'b01) begin mismatched++; $display("[TB] FAIL pre_reset_ack: got %b expected 01", acks); end
        rst_n = 1'b0;
        drive_port(0, 1'b0, 3'd0, '0, '0, 1'b0);
        #1;
        compared++; if ({bus.ack1, bus.ack0} !== 2'b00) begin mismatched++; $display("[TB] FAIL midexec_ack: got %b expected 00", {bus.ack1, bus.ack0}); end
        @(negedge clk);
        compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midexec_valid: got %b expected 0", bus.out_valid); end
        compared++; if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midexec_busy: got %b expected 0", bus.busy); end
        compared++; if (bus.out_result !== '0) begin mismatched++; $display("[TB] FAIL midexec_result: got %h expected 0", bus.out_result); end
        rst_n = 1'b1;
        last_winner = 1;
        repeat (2) @(negedge clk);
        compared++; if (bus.out_valid !== 1'b0 || {bus.ack1, bus.ack0} !== 2'b00) begin mismatched++; $display("[TB] FAIL discarded_op: valid=%b ack=%b expected 0/00", bus.out_valid, {bus.ack1, bus.ack0}); end
    endtask

    task automatic test_carry_wrap();
        logic [1:0] acks; bit ok; logic v1, v2, id, bsy, z, c; logic [W-1:0] res;
        observe_single(0, 3'd6, 32'hFFFF_FFFF, 32'h1, 1'b1, acks, ok, v1, res, id, bsy, z, c, v2);
        last_winner = 0;
        compared++; if (!ok || acks !== 2'b01) begin mismatched++; $display("[TB] FAIL wrap_ack: got %b expected 01", acks); end
        compared++; if (v1 !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_latency_valid: got %b expected 1", v1); end
        compared++; if (res !== 32'h1) begin mismatched++; $display("[TB] FAIL wrap_result: got %h expected 00000001", res); end
        compared++; if (id !== 1'b0) begin mismatched++; $display("[TB] FAIL wrap_id: got %b expected 0", id); end
        compared++; if (bsy !== 1'b1) begin mismatched++; $display("[TB] FAIL wrap_busy: got %b expected 1", bsy); end
        compared++; if (v2 !== 1'b0) begin mismatched++; $display("[TB] FAIL wrap_single_done: got %b expected 0", v2); end
`ifdef ALU_FLAGS_EN
        compared++; if ({z, c} !== 2'b01) begin mismatched++; $display("[TB] FAIL wrap_flags: got zc=%b expected 01", {z, c}); end
`endif
    endtask

    task automatic test_sub();
        logic [1:0] acks; bit ok; logic v1, v2, id, bsy, z, c; logic [W-1:0] res;
        observe_single(1, 3'd5, 32'd5, 32'd7, 1'b0, acks, ok, v1, res, id, bsy, z, c, v2);
        last_winner = 1;
        compared++; if (!ok || acks !== 2'b10) begin mismatched++; $display("[TB] FAIL sub_ack: got %b expected 10", acks); end
        compared++; if (v1 !== 1'b1 || res !== 32'hFFFF_FFFE) begin mismatched++; $display("[TB] FAIL sub_result: got valid=%b %h expected 1 FFFFFFFE", v1, res); end
        compared++; if (id !== 1'b1) begin mismatched++; $display("[TB] FAIL sub_id: got %b expected 1", id); end
`ifdef ALU_FLAGS_EN
        compared++; if ({z, c} !== 2'b00) begin mismatched++; $display("[TB] FAIL sub_flags: got zc=%b expected 00", {z, c}); end
`endif
    endtask

    task automatic test_undefined_ops();
        logic [1:0] acks; bit ok; logic v1, v2, id, bsy, z, c; logic [W-1:0] res;
        logic [2:0] ops [2];
        ops[0] = 3'd7;
        ops[1] = 3'd2;
        for (int p = 0; p < 2; p++) begin
            observe_single(p, ops[p], 32'h1234, 32'h5678, 1'b1, acks, ok, v1, res, id, bsy, z, c, v2);
            last_winner = p;
            compared++; if (!ok || v1 !== 1'b1 || res !== '0) begin mismatched++; $display("[TB] FAIL undef_op%0d_result: got valid=%b %h expected 1 0", ops[p], v1, res); end
            compared++; if (id !== p[0]) begin mismatched++; $display("[TB] FAIL undef_op%0d_id: got %b expected %0d", ops[p], id, p); end
`ifdef ALU_FLAGS_EN
            compared++; if ({z, c} !== 2'b10) begin mismatched++; $display("[TB] FAIL undef_op%0d_flags: got zc=%b expected 10", ops[p], {z, c}); end
`endif
        end
    endtask

    task automatic test_alternate();
        logic [1:0] acks; bit ok; int exp; logic [W-1:0] eres; logic ecar;
        logic [2:0] op [2]; logic [W-1:0] a [2]; logic [W-1:0] b [2]; logic cin [2];
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_winner = 1;
        bus.out_ready = 1'b1;
        for (int p = 0; p < 2; p++) begin
            op[p] = 3'($urandom_range(0, 7)); a[p] = $urandom; b[p] = $urandom; cin[p] = 1'($urandom);
            drive_port(p, 1'b1, op[p], a[p], b[p], cin[p]);
        end
        for (int i = 0; i < 4; i++) begin
            exp = 1 - last_winner;
            wait_ack(acks, ok);
            compared++; if (!ok || acks !== (exp == 1 ? 2'b10 : 2'b01)) begin mismatched++; $display("[TB] FAIL alt%0d_ack: got %b expected port %0d", i, acks, exp); end
            last_winner = exp;
            ref_alu(op[exp], a[exp], b[exp], cin[exp], eres, ecar);
            op[exp] = 3'($urandom_range(0, 7)); a[exp] = $urandom; b[exp] = $urandom; cin[exp] = 1'($urandom);
            drive_port(exp, 1'b1, op[exp], a[exp], b[exp], cin[exp]);
            @(negedge clk);
            compared++; if (bus.out_valid !== 1'b1 || bus.out_id !== exp[0] || bus.out_result !== eres) begin mismatched++; $display("[TB] FAIL alt%0d_result: got v=%b id=%b %h expected 1 %0d %h", i, bus.out_valid, bus.out_id, bus.out_result, exp, eres); end
            @(negedge clk);
        end
        drive_port(0, 1'b0, 3'd0, '0, '0, 1'b0);
        drive_port(1, 1'b0, 3'd0, '0, '0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [1:0] acks; bit ok; logic [W-1:0] eres, eres0; logic ecar, ecar0;
        logic [2:0] op; logic [W-1:0] a, b; logic cin;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        compared++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_ready: got v=%b busy=%b expected 0 0", bus.out_valid, bus.busy); end
        bus.out_ready = 1'b0;
        op = 3'd4; a = $urandom; b = $urandom; cin = 1'b0;
        ref_alu(op, a, b, cin, eres, ecar);
        drive_port(1, 1'b1, op, a, b, cin);
        wait_ack(acks, ok);
        compared++; if (!ok || acks !== 2'b10) begin mismatched++; $display("[TB] FAIL bp_ack: got %b expected 10", acks); end
        last_winner = 1;
        drive_port(1, 1'b0, op, a, b, cin);
        op = 3'd3; a = $urandom; b = $urandom;
        ref_alu(op, a, b, cin, eres0, ecar0);
        drive_port(0, 1'b1, op, a, b, cin);
        @(negedge clk);
        compared++; if (bus.out_valid !== 1'b1 || bus.out_result !== eres) begin mismatched++; $display("[TB] FAIL bp_first: got v=%b %h expected 1 %h", bus.out_valid, bus.out_result, eres); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compared++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== eres || {bus.ack1, bus.ack0} !== 2'b00 || bus.busy !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL bp_hold%0d: got v=%b %h ack=%b busy=%b expected 1 %h 00 1", i, bus.out_valid, bus.out_result, {bus.ack1, bus.ack0}, bus.busy, eres);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        compared++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_release: got v=%b busy=%b expected 0 0", bus.out_valid, bus.busy); end
        wait_ack(acks, ok);
        compared++; if (!ok || acks !== 2'b01) begin mismatched++; $display("[TB] FAIL bp_queued_ack: got %b expected 01", acks); end
        last_winner = 0;
        drive_port(0, 1'b0, op, a, b, cin);
        @(negedge clk);
        compared++; if (bus.out_valid !== 1'b1 || bus.out_id !== 1'b0 || bus.out_result !== eres0) begin mismatched++; $display("[TB] FAIL bp_queued_result: got v=%b id=%b %h expected 1 0 %h", bus.out_valid, bus.out_id, bus.out_result, eres0); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [1:0] acks; bit ok; int exp, k, p; logic [W-1:0] eres; logic ecar;
        logic [2:0] op [2]; logic [W-1:0] a [2]; logic [W-1:0] b [2]; logic cin [2]; bit pend [2];
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 40; n++) begin
            for (int q = 0; q < 2; q++) begin
                if (!pend[q] && $urandom_range(0, 2) != 0) pend[q] = 1'b1;
            end
            if (!pend[0] && !pend[1]) pend[$urandom_range(0, 1)] = 1'b1;
            for (int q = 0; q < 2; q++) begin
                if (pend[q] && !(q == 0 ? bus.req0 : bus.req1)) begin
                    op[q] = 3'($urandom_range(0, 7)); a[q] = $urandom; cin[q] = 1'($urandom);
                    b[q] = ($urandom_range(0, 3) == 0) ? a[q] : $urandom;
                    drive_port(q, 1'b1, op[q], a[q], b[q], cin[q]);
                end
            end
            exp = (pend[0] && pend[1]) ? 1 - last_winner : (pend[1] ? 1 : 0);
            wait_ack(acks, ok);
            compared++; if (!ok || acks !== (exp == 1 ? 2'b10 : 2'b01)) begin mismatched++; $display("[TB] FAIL rnd%0d_ack: got %b expected port %0d", n, acks, exp); end
            last_winner = exp;
            p = exp;
            ref_alu(op[p], a[p], b[p], cin[p], eres, ecar);
            pend[p] = 1'b0;
            drive_port(p, 1'b0, op[p], a[p], b[p], cin[p]);
            k = $urandom_range(0, 3);
            @(negedge clk);
            compared++; if (bus.out_valid !== 1'b1 || bus.out_id !== p[0] || bus.out_result !== eres) begin mismatched++; $display("[TB] FAIL rnd%0d_result: op=%0d got v=%b id=%b %h expected 1 %0d %h", n, op[p], bus.out_valid, bus.out_id, bus.out_result, p, eres); end
`ifdef ALU_FLAGS_EN
            compared++; if ({bus.out_zero, bus.out_carry} !== {eres == '0, ecar}) begin mismatched++; $display("[TB] FAIL rnd%0d_flags: op=%0d got zc=%b expected %b", n, op[p], {bus.out_zero, bus.out_carry}, {eres == '0, ecar}); end
`endif
            for (int j = 0; j < k; j++) begin
                @(negedge clk);
                compared++; if (bus.out_valid !== 1'b1 || bus.out_result !== eres || {bus.ack1, bus.ack0} !== 2'b00) begin mismatched++; $display("[TB] FAIL rnd%0d_stall: got v=%b %h ack=%b expected 1 %h 00", n, bus.out_valid, bus.out_result, {bus.ack1, bus.ack0}, eres); end
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rnd%0d_release: got v=%b expected 0", n, bus.out_valid); end
            bus.out_ready = 1'b0;
        end
        drive_port(0, 1'b0, 3'd0, '0, '0, 1'b0);
        drive_port(1, 1'b0, 3'd0, '0, '0, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        mismatched++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.out_ready = 1'b0;
        drive_port(0, 1'b0, 3'd0, '0, '0, 1'b0);
        drive_port(1, 1'b0, 3'd0, '0, '0, 1'b0);
        $display("[TB] starting alu_share_arbiter bench");
        test_reset();
        test_carry_wrap();
        test_sub();
        test_undefined_ops();
        test_alternate();
        test_backpressure();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
